// File: rtl/softex_pkg.sv
// Shared SoftEx types and constants used by the streamer-side helpers.
package softex_pkg;

   localparam int unsigned DATA_W = 32;

   // Only the job length is consumed by the strobe packer.
   typedef struct packed {
      logic [31:0] tot_len;
   } hci_addressgen_ctrl_t;

   typedef struct packed {
      hci_addressgen_ctrl_t addressgen_ctrl;
   } hci_streamer_ctrl_t;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DRAIN
   } softex_strb_packer_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE stream interface: valid/ready handshake with byte strobes.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, output data, output strb, input ready);
   modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/softex_streamer_strb_packer.sv
// Repacks LSB-aligned partial-strobe beats into dense full-width beats,
// flushing the leftover bytes as one partial beat at end of job.
module softex_streamer_strb_packer
   import softex_pkg::*;
#(
   parameter int unsigned DW = DATA_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  hci_streamer_ctrl_t     stream_ctrl_i,
   hwpe_stream_intf_stream.sink   stream_i,
   hwpe_stream_intf_stream.source stream_o,
   output logic                   done_o
);

   localparam int unsigned N  = DW / 8;
   localparam int unsigned CW = $clog2(N) + 1;
   localparam int unsigned MW = (2 * N - 1) * 8;

   // Strobe with the lowest cnt bits set.
   function automatic logic [N-1:0] strb_mask(input logic [CW-1:0] cnt);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) begin
         m[i] = (i < int'(cnt));
      end
      return m;
   endfunction

   softex_strb_packer_state_e state_q, state_d;

   logic [31:0]        cnt_q;
   logic [(N-1)*8-1:0] res_q;
   logic [CW-1:0]      res_cnt_q;
   logic               out_valid_q;
   logic [DW-1:0]      out_data_q;
   logic [N-1:0]       out_strb_q;

   logic [CW-1:0] k;
   logic [CW-1:0] sum;
   logic [CW-1:0] rem;
   logic [CW-1:0] new_res_cnt;
   logic          full;
   logic          last;
   logic          out_free;
   logic          in_ready;
   logic          in_hs;
   logic          out_hs;
   logic          flush_load;
   logic          done;
   logic [MW-1:0] res_ext;
   logic [MW-1:0] in_ext;
   logic [MW-1:0] merged;

   assign out_free    = !out_valid_q | stream_o.ready;
   assign in_ready    = (state_q == RUN) & out_free;
   assign in_hs       = stream_i.valid & in_ready;
   assign out_hs      = out_valid_q & stream_o.ready;
   assign last        = (cnt_q == (stream_ctrl_i.addressgen_ctrl.tot_len - 32'd1));
   assign sum         = res_cnt_q + k;
   assign full        = (sum >= CW'(N));
   assign rem         = sum - CW'(N);
   assign new_res_cnt = full ? rem : sum;
   assign res_ext     = {{(N*8){1'b0}}, res_q};
   assign in_ext      = {{((N-1)*8){1'b0}}, stream_i.data};

   // Count valid input bytes; the strobe is LSB-contiguous so popcount is the length.
   always_comb begin
      k = '0;
      for (int i = 0; i < N; i++) begin
         k = k + CW'(stream_i.strb[i]);
      end
   end

   // Concatenate residual bytes and valid input bytes; unused positions stay zero.
   always_comb begin
      merged = '0;
      for (int i = 0; i < 2 * N - 1; i++) begin
         if (i < int'(res_cnt_q)) begin
            merged[i*8 +: 8] = res_ext[i*8 +: 8];
         end else if ((i - int'(res_cnt_q)) < int'(k)) begin
            merged[i*8 +: 8] = in_ext[(i - int'(res_cnt_q))*8 +: 8];
         end
      end
   end

   // Next-state logic: accept beats, then flush leftovers, then wait for the output to empty.
   always_comb begin
      state_d    = state_q;
      flush_load = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         RUN: begin
            if (in_hs && last) begin
               state_d = (new_res_cnt != '0) ? FLUSH : DRAIN;
            end
         end
         FLUSH: begin
            if (out_free) begin
               flush_load = 1'b1;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (out_free) begin
               done    = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Beat counter, residual buffer and single-entry output register.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q       <= '0;
         res_q       <= '0;
         res_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
      end else begin
         if (out_hs) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
         end
         if (in_hs) begin
            cnt_q <= last ? 32'd0 : cnt_q + 32'd1;
            if (full) begin
               out_valid_q <= 1'b1;
               out_data_q  <= merged[N*8-1:0];
               out_strb_q  <= '1;
               res_q       <= merged[MW-1:N*8];
               res_cnt_q   <= rem;
            end else begin
               res_q     <= merged[(N-1)*8-1:0];
               res_cnt_q <= sum;
            end
         end
         if (flush_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {8'h00, res_q};
            out_strb_q  <= strb_mask(res_cnt_q);
            res_q       <= '0;
            res_cnt_q   <= '0;
         end
      end
   end

   assign stream_i.ready = in_ready;
   assign stream_o.valid = out_valid_q;
   assign stream_o.data  = out_data_q;
   assign stream_o.strb  = out_strb_q;
   assign done_o         = done;

endmodule
